// File: rtl/temp_key_capture.sv
// PS/2 scan-code to two-digit temperature set-point capture.
// Filters break/extended sequences and typematic repeats, stages up to two digits, publishes on Enter.
module temp_key_capture (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] DECENAS,
  output logic [7:0] UNIDADES,
  output logic       commit,
  output logic [1:0] entry_cnt
);

  localparam logic [7:0] K_ZERO  = 8'h45;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic [7:0] held_q, held_d;
  logic [7:0] d1_q, d1_d, d2_q, d2_d;
  logic [7:0] dec_q, dec_d, uni_q, uni_d;
  logic       commit_q, commit_d;
  logic       fsm_vld, is_dig, is_ent, is_bs;

  // Prefix and repeat filter: only a fresh, unprefixed byte reaches the FSM
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    held_d  = held_q;
    fsm_vld = 1'b0;
    if (rx_done) begin
      if (rx_data == K_EXT)       ext_d = 1'b1;
      else if (rx_data == K_BRK)  brk_d = 1'b1;
      else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (brk_q) held_d = 8'h00;
      end else if (rx_data != held_q) begin
        held_d  = rx_data;
        fsm_vld = 1'b1;
      end
    end
  end

  always_comb begin
    is_ent = (rx_data == K_ENTER);
    is_bs  = (rx_data == K_BKSP);
    case (rx_data)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_dig = 1'b1;
      default:                           is_dig = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      held_q   <= 8'h00;
      d1_q     <= K_ZERO;
      d2_q     <= K_ZERO;
      dec_q    <= K_ZERO;
      uni_q    <= K_ZERO;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      held_q   <= held_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      dec_q    <= dec_d;
      uni_q    <= uni_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    if (fsm_vld) begin
      case (state_q)
        IDLE: if (is_dig) begin
          d1_d    = rx_data;
          state_d = ONE;
        end
        ONE: begin
          if (is_dig) begin
            d2_d    = rx_data;
            state_d = TWO;
          end else if (is_ent || is_bs) begin
            state_d = IDLE;
          end
        end
        TWO:     if (is_ent || is_bs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A lone staged digit publishes as units with a leading zero
  always_comb begin
    dec_d    = dec_q;
    uni_d    = uni_q;
    commit_d = 1'b0;
    if (fsm_vld && is_ent) begin
      case (state_q)
        ONE: begin
          dec_d    = K_ZERO;
          uni_d    = d1_q;
          commit_d = 1'b1;
        end
        TWO: begin
          dec_d    = d1_q;
          uni_d    = d2_q;
          commit_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DECENAS   = dec_q;
  assign UNIDADES  = uni_q;
  assign commit    = commit_q;
  assign entry_cnt = state_q;

endmodule
